// File: rtl/exec_responder.sv
// Operand-request responder: integer register file plus the RV32I ALU that
// serves the decoder's two operand beats and acknowledges with alu_op_done.
module exec_responder #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rs_valid,
    input  logic              rs_sel,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              rs_store,
    input  logic              alu_imme_rs2_sel,
    input  logic [DATA_W-1:0] alu_imme,
    input  logic [3:0]        alu_opcode,
    input  logic [REG_AW-1:0] rd_addr,
    output logic              alu_op_done,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              proto_err
);
    localparam int NREG = 1 << REG_AW;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] regs_r [NREG];
    logic [DATA_W-1:0] op_a_r;
    logic [DATA_W-1:0] op_b_r;
    logic [DATA_W-1:0] res_r;
    logic              b_is_imm_r;
    logic              is_mem_r;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] alu_s;
    logic [2:0]        op_sel_s;
    logic              sub_s;
    logic [4:0]        shamt_s;
    logic              wr_en_s;
    logic              unused_s;

    // Beat order alone decides rs1/rs2, so rs_sel carries no information here.
    assign unused_s = rs_sel;

    // The write uses the wb_addr captured with the result; x0 is never stored.
    assign wr_en_s = (state_r == DONE) && !is_mem_r && (wb_addr != '0);

    // Combinational register read, x0 hardwired to zero, write-first on collision.
    always_comb begin
        rd_data_s = '0;
        if (rs_addr == '0) begin
            rd_data_s = '0;
        end else if (wr_en_s && (wb_addr == rs_addr)) begin
            rd_data_s = res_r;
        end else begin
            rd_data_s = regs_r[rs_addr];
        end
    end

    // ALU: memory requests always compute base + offset.
    always_comb begin
        op_sel_s = is_mem_r ? 3'b000 : alu_opcode[2:0];
        sub_s    = !is_mem_r && alu_opcode[3] && !b_is_imm_r;
        shamt_s  = op_b_r[4:0];
        alu_s    = '0;
        case (op_sel_s)
            3'b000:  alu_s = sub_s ? (op_a_r - op_b_r) : (op_a_r + op_b_r);
            3'b001:  alu_s = op_a_r << shamt_s;
            3'b010:  alu_s = DATA_W'($signed(op_a_r) < $signed(op_b_r));
            3'b011:  alu_s = DATA_W'(op_a_r < op_b_r);
            3'b100:  alu_s = op_a_r ^ op_b_r;
            3'b101:  alu_s = alu_opcode[3] ? DATA_W'($signed(op_a_r) >>> shamt_s)
                                           : (op_a_r >> shamt_s);
            3'b110:  alu_s = op_a_r | op_b_r;
            3'b111:  alu_s = op_a_r & op_b_r;
            default: alu_s = '0;
        endcase
    end

    // Register file storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_r[wb_addr] <= res_r;
        end
    end

    // Request FSM with registered completion, writeback and address outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= WAIT_A;
            op_a_r      <= '0;
            op_b_r      <= '0;
            res_r       <= '0;
            b_is_imm_r  <= 1'b0;
            is_mem_r    <= 1'b0;
            alu_op_done <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            proto_err   <= 1'b0;
        end else begin
            alu_op_done <= 1'b0;
            mem_req     <= 1'b0;
            wb_valid    <= 1'b0;
            case (state_r)
                WAIT_A: begin
                    if (rs_valid) begin
                        op_a_r  <= rd_data_s;
                        state_r <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (rs_valid) begin
                        op_b_r     <= alu_imme_rs2_sel ? alu_imme : rd_data_s;
                        b_is_imm_r <= alu_imme_rs2_sel;
                        is_mem_r   <= rs_store;
                        state_r    <= EXEC;
                    end
                end
                EXEC: begin
                    res_r       <= alu_s;
                    alu_op_done <= 1'b1;
                    if (is_mem_r) begin
                        mem_req  <= 1'b1;
                        mem_addr <= alu_s;
                    end else begin
                        wb_valid <= 1'b1;
                        wb_addr  <= rd_addr;
                        wb_data  <= alu_s;
                    end
                    if (rs_valid) begin
                        proto_err <= 1'b1;
                    end
                    state_r <= DONE;
                end
                DONE: begin
                    if (rs_valid) begin
                        proto_err <= 1'b1;
                    end
                    state_r <= WAIT_A;
                end
                default: state_r <= WAIT_A;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_responder.sv
// Directed bench for exec_responder: register ops, immediates, shifts,
// compares, address generation, x0 handling, protocol error and reset.
module tb_exec_responder;
    logic        clk;
    logic        reset_n;
    logic        rs_valid;
    logic        rs_sel;
    logic [4:0]  rs_addr;
    logic        rs_store;
    logic        alu_imme_rs2_sel;
    logic [31:0] alu_imme;
    logic [3:0]  alu_opcode;
    logic [4:0]  rd_addr;
    logic        alu_op_done;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        proto_err;

    int errors;
    int checks;

    logic        done3, wbv3, memr3, done4, wbv4, memr4, any_s;
    logic [4:0]  wba3;
    logic [31:0] wbd3, mema3;

    exec_responder #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset_n(reset_n), .rs_valid(rs_valid), .rs_sel(rs_sel),
        .rs_addr(rs_addr), .rs_store(rs_store), .alu_imme_rs2_sel(alu_imme_rs2_sel),
        .alu_imme(alu_imme), .alu_opcode(alu_opcode), .rd_addr(rd_addr),
        .alu_op_done(alu_op_done), .mem_req(mem_req), .mem_addr(mem_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Beats at T0/T1, optional stray beat in EXEC (T2), sample at T3 and T4.
    task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic sel,
                          input logic [31:0] imm, input logic [3:0] opc,
                          input logic [4:0] rd, input logic st, input logic extra);
        @(posedge clk); #1;
        rs_valid = 1'b1; rs_sel = 1'b0; rs_addr = a; rs_store = st;
        alu_imme_rs2_sel = sel; alu_imme = imm; alu_opcode = opc; rd_addr = rd;
        @(posedge clk); #1;
        rs_sel = 1'b1; rs_addr = b;
        @(posedge clk); #1;
        rs_valid = extra;
        @(posedge clk); #1;
        rs_valid = 1'b0;
        done3 = alu_op_done; wbv3 = wb_valid; wba3 = wb_addr; wbd3 = wb_data;
        memr3 = mem_req; mema3 = mem_addr;
        @(posedge clk); #1;
        done4 = alu_op_done; wbv4 = wb_valid; memr4 = mem_req;
    endtask

    task automatic expect_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, "_done"}, {31'd0, done3}, 32'd1);
        chk({tag, "_wbv"},  {31'd0, wbv3},  32'd1);
        chk({tag, "_wba"},  {27'd0, wba3},  {27'd0, rd});
        chk({tag, "_wbd"},  wbd3,           data);
        chk({tag, "_memr"}, {31'd0, memr3}, 32'd0);
        chk({tag, "_pulse"}, {29'd0, done4, wbv4, memr4}, 32'd0);
    endtask

    initial begin
        errors = 0; checks = 0;
        reset_n = 1'b0; rs_valid = 1'b0; rs_sel = 1'b0; rs_addr = 5'd0; rs_store = 1'b0;
        alu_imme_rs2_sel = 1'b0; alu_imme = 32'd0; alu_opcode = 4'd0; rd_addr = 5'd0;
        #12;
        chk("rst_ctl", {28'd0, alu_op_done, mem_req, wb_valid, proto_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // Preload and R-type add/sub
        run_op(5'd0, 5'd0, 1'b1, 32'd7,  4'b0000, 5'd1, 1'b0, 1'b0); expect_wb("ld_x1", 5'd1, 32'd7);
        run_op(5'd0, 5'd0, 1'b1, 32'd10, 4'b0000, 5'd2, 1'b0, 1'b0); expect_wb("ld_x2", 5'd2, 32'd10);
        run_op(5'd1, 5'd2, 1'b0, 32'd0,  4'b0000, 5'd3, 1'b0, 1'b0); expect_wb("add", 5'd3, 32'd17);
        run_op(5'd1, 5'd2, 1'b0, 32'd0,  4'b1000, 5'd3, 1'b0, 1'b0); expect_wb("sub", 5'd3, 32'hFFFF_FFFD);
        run_op(5'd3, 5'd0, 1'b0, 32'd0,  4'b0000, 5'd5, 1'b0, 1'b0); expect_wb("rd_x3", 5'd5, 32'hFFFF_FFFD);

        // ADDI with instr[30] set must still add
        run_op(5'd0, 5'd0, 1'b1, 32'd5, 4'b0000, 5'd1, 1'b0, 1'b0);
        run_op(5'd1, 5'd0, 1'b1, 32'hFFFF_FC00, 4'b1000, 5'd6, 1'b0, 1'b0);
        expect_wb("addi_b10", 5'd6, 32'hFFFF_FC05);

        // Shifts, compares and logic with x1 = 0x80000000
        run_op(5'd0, 5'd0, 1'b1, 32'h8000_0000, 4'b0000, 5'd1, 1'b0, 1'b0);
        run_op(5'd1, 5'd0, 1'b1, 32'd4, 4'b1101, 5'd7, 1'b0, 1'b0); expect_wb("sra", 5'd7, 32'hF800_0000);
        run_op(5'd1, 5'd0, 1'b1, 32'd4, 4'b0101, 5'd7, 1'b0, 1'b0); expect_wb("srl", 5'd7, 32'h0800_0000);
        run_op(5'd1, 5'd0, 1'b1, 32'd4, 4'b0001, 5'd7, 1'b0, 1'b0); expect_wb("sll", 5'd7, 32'h0000_0000);
        run_op(5'd1, 5'd0, 1'b1, 32'hFFFF_FFFF, 4'b0011, 5'd7, 1'b0, 1'b0); expect_wb("sltu", 5'd7, 32'd1);
        run_op(5'd1, 5'd0, 1'b1, 32'd4, 4'b0010, 5'd7, 1'b0, 1'b0); expect_wb("slt", 5'd7, 32'd1);
        run_op(5'd1, 5'd0, 1'b1, 32'h0000_00F0, 4'b0100, 5'd7, 1'b0, 1'b0); expect_wb("xor", 5'd7, 32'h8000_00F0);
        run_op(5'd1, 5'd0, 1'b1, 32'd1, 4'b0110, 5'd7, 1'b0, 1'b0); expect_wb("or", 5'd7, 32'h8000_0001);
        run_op(5'd1, 5'd0, 1'b1, 32'hC000_0001, 4'b0111, 5'd7, 1'b0, 1'b0); expect_wb("and", 5'd7, 32'h8000_0000);

        // Effective address: forced ADD, no register write
        run_op(5'd0, 5'd0, 1'b1, 32'h0000_1000, 4'b0000, 5'd4, 1'b0, 1'b0);
        run_op(5'd4, 5'd0, 1'b1, 32'hFFFF_FFF0, 4'b0010, 5'd4, 1'b1, 1'b0);
        chk("mem_done", {31'd0, done3}, 32'd1);
        chk("mem_req", {31'd0, memr3}, 32'd1);
        chk("mem_addr", mema3, 32'h0000_0FF0);
        chk("mem_no_wb", {31'd0, wbv3}, 32'd0);
        chk("mem_pulse", {30'd0, done4, memr4}, 32'd0);
        run_op(5'd4, 5'd0, 1'b0, 32'd0, 4'b0000, 5'd12, 1'b0, 1'b0); expect_wb("x4_kept", 5'd12, 32'h0000_1000);

        // x0 write is discarded but still strobed
        run_op(5'd0, 5'd0, 1'b1, 32'h55, 4'b0000, 5'd0, 1'b0, 1'b0); expect_wb("wr_x0", 5'd0, 32'h55);
        run_op(5'd0, 5'd0, 1'b0, 32'd0, 4'b0000, 5'd11, 1'b0, 1'b0); expect_wb("rd_x0", 5'd11, 32'd0);

        // Protocol error: stray beat during EXEC, sticky afterwards
        chk("proto_clear", {31'd0, proto_err}, 32'd0);
        run_op(5'd0, 5'd0, 1'b1, 32'd3, 4'b0000, 5'd13, 1'b0, 1'b1); expect_wb("proto_op", 5'd13, 32'd3);
        chk("proto_set", {31'd0, proto_err}, 32'd1);
        run_op(5'd13, 5'd0, 1'b0, 32'd0, 4'b0000, 5'd14, 1'b0, 1'b0); expect_wb("after_proto", 5'd14, 32'd3);
        chk("proto_sticky", {31'd0, proto_err}, 32'd1);

        // Reset while in EXEC aborts the request
        @(posedge clk); #1;
        rs_valid = 1'b1; rs_sel = 1'b0; rs_addr = 5'd1; rs_store = 1'b0;
        alu_imme_rs2_sel = 1'b0; alu_imme = 32'd0; alu_opcode = 4'b0000; rd_addr = 5'd9;
        @(posedge clk); #1; rs_sel = 1'b1; rs_addr = 5'd0;
        @(posedge clk); #1; rs_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {28'd0, alu_op_done, mem_req, wb_valid, proto_err}, 32'd0);
        chk("mid_rst_wb", {wb_data[26:0], wb_addr}, 32'd0);
        chk("mid_rst_wbd", wb_data, 32'd0);
        chk("mid_rst_mem", mem_addr, 32'd0);
        @(posedge clk); @(negedge clk); reset_n = 1'b1;
        any_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            any_s = any_s | alu_op_done | wb_valid | mem_req;
        end
        chk("no_done_after_rst", {31'd0, any_s}, 32'd0);
        run_op(5'd1, 5'd0, 1'b0, 32'd0, 4'b0000, 5'd9, 1'b0, 1'b0); expect_wb("post_rst_x1", 5'd9, 32'd0);
        run_op(5'd3, 5'd4, 1'b0, 32'd0, 4'b0110, 5'd10, 1'b0, 1'b0); expect_wb("post_rst_x3x4", 5'd10, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
